// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage, byte-serial loads/stores over a shared RAM port.
// Optional MEM_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module mem_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            rd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [2:0]            mem_sel_i,
  input  logic                  mem_we_i,
  input  logic                  load_sign_i,
  input  logic [31:0]           reg2_i,
  input  logic                  mem_gnt_i,
  input  logic [7:0]            mem_din_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_a_o,
  output logic                  mem_wr_o,
  output logic [7:0]            mem_dout_o,
  output logic [4:0]            rd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stall_req_o,
  output logic                  misalign_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  state_t                state;
  logic [2:0]            n;
  logic [2:0]            cnt;
  logic [ADDR_WIDTH-1:0] base;
  logic [31:0]           sdata;
  logic [31:0]           data;
  logic                  sign;
  logic                  we;
  logic                  pend;
  logic [1:0]            pidx;
  logic                  sel_ok;
  logic                  mis;
  logic                  rej;
  logic                  issue;
  logic                  last;
  logic [31:0]           ext;

  assign sel_ok = (mem_sel_i == 3'd1) |
                  (mem_sel_i == 3'd2) |
                  (mem_sel_i == 3'd4);

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = ((mem_sel_i == 3'd2) & mem_addr_i[0]) |
               ((mem_sel_i == 3'd4) & (|mem_addr_i[1:0]));
`else
  assign mis = 1'b0;
  assign rej = 1'b0;
`endif

  assign issue = (state == ACCESS) & mem_gnt_i;
  assign last  = (cnt + 3'd1) == n;

  // Access sequencer: latch the request, walk bytes, capture read data one cycle late
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n     <= '0;
      cnt   <= '0;
      base  <= '0;
      sdata <= '0;
      data  <= '0;
      sign  <= 1'b0;
      we    <= 1'b0;
      pend  <= 1'b0;
      pidx  <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      rej   <= 1'b0;
`endif
    end else begin
      pend <= issue;
      if (issue) pidx <= cnt[1:0];
      if (pend) data[{pidx, 3'b000} +: 8] <= mem_din_i;
      case (state)
        IDLE: begin
          if (sel_ok) begin
            n     <= mem_sel_i;
            base  <= mem_addr_i;
            sdata <= reg2_i;
            sign  <= load_sign_i;
            we    <= mem_we_i;
            cnt   <= '0;
            data  <= '0;
            state <= mis ? DONE : ACCESS;
`ifdef MEM_MISALIGN_CHECK_EN
            rej   <= mis;
`endif
          end
        end
        ACCESS: begin
          if (mem_gnt_i) begin
            cnt <= cnt + 3'd1;
            if (last) state <= we ? DONE : WAIT;
          end
        end
        WAIT: state <= DONE;
        DONE: begin
          state <= IDLE;
`ifdef MEM_MISALIGN_CHECK_EN
          rej   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Extend the assembled load from its top byte
  always_comb begin
    ext = data;
    case (n)
      3'd1:    ext = {{24{sign & data[7]}}, data[7:0]};
      3'd2:    ext = {{16{sign & data[15]}}, data[15:0]};
      default: ext = data;
    endcase
  end

  assign mem_req_o  = ~rst & (state == ACCESS);
  assign mem_wr_o   = mem_req_o & we;
  assign mem_a_o    = base + ADDR_WIDTH'(cnt);
  assign mem_dout_o = sdata[{cnt[1:0], 3'b000} +: 8];
  assign rd_o       = rd_i;

  assign stall_req_o = ~rst & (((state == IDLE) & sel_ok) |
                               (state == ACCESS) |
                               (state == WAIT));

  assign wreg_o = ~rst & wreg_i &
                  (((state == IDLE) & ~sel_ok) |
                   ((state == DONE) & ~rej));

  assign misalign_o = ~rst & (state == DONE) & rej;

  // Result mux: pass-through when idle, load/store result on completion
  always_comb begin
    wdata_o = wdata_i;
    if (state == DONE) wdata_o = (we | rej) ? 32'd0 : ext;
  end

endmodule
